// File: rtl/arm_fetch.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, and an
// in-order instruction queue toward the decoder with redirect flush/discard.
module arm_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    input  logic        ins_ready
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    entry_t        q [QDEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, outstanding, discard;
    logic [CW:0]   inflight;
    logic [31:0]   fetch_pc, rsp_pc, redir_pc;
    logic          req_fire, rsp_take, push, pop;

    // Credits cover both queued words and requests still in flight, so a
    // returning word always has a free slot.
    assign inflight       = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = !rst && !redirect_valid && (inflight < QD);
    assign imem_req_addr  = fetch_pc;
    assign redir_pc       = redirect_pc & ~32'h3;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_take = imem_rsp_valid && (outstanding != '0);
    assign push     = rsp_take && (discard == '0) && !redirect_valid;
    assign pop      = ins_valid && ins_ready && !redirect_valid;

    assign ins_valid = (count != '0);
    assign ins       = q[head].word;
    assign ins_pc    = q[head].pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
            if (redirect_valid) begin
                // Every request still out belongs to the old stream.
                fetch_pc <= redir_pc;
                rsp_pc   <= redir_pc;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                discard  <= outstanding - CW'(rsp_take);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (rsp_take && discard != '0) discard <= discard - CW'(1);
                if (push) begin
                    q[tail] <= entry_t'{pc: rsp_pc, word: imem_rsp_data};
                    tail    <= tail + PW'(1);
                    rsp_pc  <= rsp_pc + 32'd4;
                end
                if (pop) head <= head + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_arm_fetch.sv
// Randomized bench for arm_fetch: in-order variable-latency memory model and an
// instruction-stream model (expected fetch address and expected decoded PC).
module tb_arm_fetch;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          QD  = 4;

    logic        clk = 0, rst = 1;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ins_valid, ins_ready;
    logic [31:0] ins, ins_pc;

    always #5 clk = ~clk;

    arm_fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc), .ins_ready(ins_ready)
    );

    int n_chk = 0, n_err = 0, cyc = 0, n_vld = 0;
    int lat_min = 1, lat_max = 1, rsp_pct = 100, rdy_pct = 100, ins_pct = 100, rdir_pct = 0;
    logic        nxt_rst = 1, nxt_rdir = 0, coinc = 0, coinc_hit = 0, spur = 0;
    logic [31:0] nxt_rpc = 0;
    logic [31:0] exp_fetch = RPC, exp_pc = RPC;
    logic [31:0] pa[$];
    int          pd[$];
    logic [31:0] acc[$], pops[$];
    logic        prev_stall = 0, prev_rdir = 0;
    logic [31:0] prev_addr = 0, prev_rtgt = 0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic observe();
        if (prev_stall) chk("addr_hold", imem_req_addr, prev_addr);
        if (prev_rdir) begin
            chk("rdir_ins_valid", 32'(ins_valid), 0);
            chk("rdir_addr", imem_req_addr, prev_rtgt);
        end
        prev_rdir  = redirect_valid;
        prev_stall = 0;
        if (redirect_valid) begin
            chk("rdir_req_valid", 32'(imem_req_valid), 0);
            prev_rtgt = redirect_pc & ~32'h3;
            exp_fetch = prev_rtgt;
            exp_pc    = prev_rtgt;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_fetch);
                exp_fetch += 4;
                acc.push_back(imem_req_addr);
                pa.push_back(imem_req_addr);
                pd.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                chk("credit", 32'(pa.size() <= QD), 1);
            end
            prev_stall = imem_req_valid && !imem_req_ready;
            prev_addr  = imem_req_addr;
            if (ins_valid && ins_ready) begin
                chk("ins_pc", ins_pc, exp_pc);
                chk("ins", ins, memw(exp_pc));
                pops.push_back(ins_pc);
                exp_pc += 4;
            end
        end
        if (ins_valid) n_vld++;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        rst            = nxt_rst;
        imem_rsp_valid = 0;
        imem_rsp_data  = 0;
        redirect_valid = 0;
        if (rst) begin
            pa.delete();
            pd.delete();
        end else if (spur && pa.size() == 0) begin
            imem_rsp_valid = 1;
            imem_rsp_data  = $urandom;
            spur = 0;
        end else if (pa.size() != 0 && pd[0] <= cyc && $urandom_range(99) < rsp_pct) begin
            imem_rsp_valid = 1;
            imem_rsp_data  = memw(pa[0]);
            void'(pa.pop_front());
            void'(pd.pop_front());
        end
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        ins_ready      = ($urandom_range(99) < ins_pct);
        if (!rst) begin
            if (nxt_rdir) begin
                redirect_valid = 1; redirect_pc = nxt_rpc; nxt_rdir = 0;
            end else if (coinc && imem_rsp_valid && ins_valid && ins_ready) begin
                redirect_valid = 1; redirect_pc = $urandom; coinc = 0; coinc_hit = 1;
            end else if ($urandom_range(99) < rdir_pct) begin
                redirect_valid = 1; redirect_pc = $urandom;
            end
        end
        @(negedge clk);
        if (!rst) observe();
    endtask

    task automatic do_reset();
        nxt_rst = 1;
        tick();
        tick();
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_addr", imem_req_addr, RPC);
        chk("rst_ins_valid", 32'(ins_valid), 0);
        chk("rst_ins", ins, 0);
        chk("rst_ins_pc", ins_pc, 0);
        prev_stall = 0; prev_rdir = 0;
        exp_fetch = RPC; exp_pc = RPC;
        acc.delete(); pops.delete();
        nxt_rst = 0;
    endtask

    initial begin
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        redirect_valid = 0; redirect_pc = 0; ins_ready = 0;

        // latency 1, everything ready: 2-cycle fetch-to-decode, then 1/cycle
        do_reset();
        tick();
        chk("t1_req_valid", 32'(imem_req_valid), 1);
        chk("t1_addr", imem_req_addr, RPC);
        tick();
        chk("t1_ins_valid_c1", 32'(ins_valid), 0);
        tick();
        chk("t1_ins_valid_c2", 32'(ins_valid), 1);
        chk("t1_ins_pc_c2", ins_pc, RPC);
        n_vld = 0;
        repeat (16) tick();
        chk("t1_throughput", n_vld, 16);

        // decoder stalled: credits cap accepted requests at QDEPTH
        do_reset();
        ins_pct = 0;
        repeat (12) tick();
        chk("t2_acc", acc.size(), QD);
        chk("t2_req_valid", 32'(imem_req_valid), 0);
        ins_pct = 100;
        repeat (6) tick();
        chk("t2_resume", acc.size() > 4 ? acc[4] : 32'hDEAD_BEEF, RPC + 32'h10);

        // latency 3, redirect with three requests in flight
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && pa.size() < 3; i++) tick();
        chk("t3_outstanding", pa.size(), 3);
        nxt_rdir = 1; nxt_rpc = 32'h0000_1002;
        tick();
        pops.delete();
        repeat (20) tick();
        chk("t3_first_pc", pops.size() != 0 ? pops[0] : 32'hDEAD_BEEF, 32'h0000_1000);

        // redirect coinciding with a response and a pop
        lat_min = 1; lat_max = 1;
        do_reset();
        coinc = 1; coinc_hit = 0;
        for (int i = 0; i < 40 && !coinc_hit; i++) tick();
        chk("t4_hit", 32'(coinc_hit), 1);
        tick();
        chk("t4_ins_valid", 32'(ins_valid), 0);
        repeat (10) tick();

        // address wrap at top of memory
        nxt_rdir = 1; nxt_rpc = 32'hFFFF_FFF8;
        tick();
        acc.delete(); pops.delete();
        repeat (12) tick();
        chk("t5_acc0", acc.size() > 2 ? acc[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        chk("t5_acc1", acc.size() > 2 ? acc[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        chk("t5_acc2", acc.size() > 2 ? acc[2] : 32'hDEAD_BEEF, 32'h0000_0000);
        chk("t5_pop0", pops.size() > 2 ? pops[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        chk("t5_pop2", pops.size() > 2 ? pops[2] : 32'hDEAD_BEEF, 32'h0000_0000);

        // random backpressure, latency, gaps and redirects
        lat_min = 1; lat_max = 4; rdy_pct = 50; ins_pct = 70; rsp_pct = 80; rdir_pct = 3;
        repeat (3000) tick();
        rdir_pct = 0;

        // mid-operation reset, then a stray response with nothing in flight
        do_reset();
        rdy_pct = 0; spur = 1;
        repeat (4) tick();
        chk("t7_spur_ins_valid", 32'(ins_valid), 0);
        chk("t7_spur_consumed", 32'(spur), 0);
        lat_min = 1; lat_max = 1; rdy_pct = 100; ins_pct = 100; rsp_pct = 100;
        pops.delete();
        repeat (8) tick();
        chk("t7_first_pc", pops.size() != 0 ? pops[0] : 32'hDEAD_BEEF, RPC);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/arm_fetch.md
# arm_fetch

Instruction fetch stage of the ARM core, directly upstream of the instruction decoder. Holds the PC and issues word fetches to instruction memory over a valid/ready request channel with in-order, variable-latency responses. Buffers returned words with their PCs in a small queue and presents them to the decoder under a valid/ready handshake. A branch redirect flushes the queue and discards stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
- QDEPTH, 4, queue entries and maximum outstanding requests (power of 2, ≥2)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch word address (bits [1:0] always 0)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response word valid (in request order, ≥1 cycle after acceptance)
- imem_rsp_data  in  32  response instruction word
- redirect_valid  in  1  branch/BX taken, one-cycle pulse
- redirect_pc  in  32  new fetch target ([1:0] forced to 0 internally)
- ins_valid  out  1  queue head valid toward decoder
- ins  out  32  instruction word (drives decoder I input)
- ins_pc  out  32  address of ins
- ins_ready  in  1  decoder consumes head

## Operation
- State: fetch_pc, rsp_pc, queue (QDEPTH × {pc, word}), count, outstanding, discard.
- Request: imem_req_valid = !redirect_valid && (outstanding + count < QDEPTH); imem_req_addr = fetch_pc. Handshake (valid && ready): fetch_pc += 4, outstanding += 1.
- Response: every imem_rsp_valid decrements outstanding. If discard > 0 or redirect_valid in the same cycle: word dropped, discard −= 1 (when discard > 0). Otherwise push {rsp_pc, imem_rsp_data}, rsp_pc += 4.
- Consume: ins_valid = (count != 0); ins/ins_pc = head entry. ins_valid && ins_ready pops head.
- Simultaneous push and pop: count unchanged. Credit rule guarantees push never finds the queue full.
- Redirect (highest priority): fetch_pc ← rsp_pc ← {redirect_pc[31:2],2'b00}; count ← 0 (pop same cycle ignored); discard ← outstanding − (imem_rsp_valid ? 1 : 0), with discard tracking applied as above. outstanding keeps counting stale requests until they return.
- imem_rsp_valid with outstanding == 0: protocol error, ignored, no state change.
- Arithmetic: PCs 32-bit, wrap 32'hFFFF_FFFC → 0. Counters ceil(log2(QDEPTH))+1 bits, never exceed QDEPTH.

## Timing
- Reset values: imem_req_valid 0 during rst; imem_req_addr = RESET_PC; ins_valid 0; ins 0; ins_pc 0; count, outstanding, discard 0; queue storage 0.
- First request presented the cycle after rst deasserts, address RESET_PC.
- No bypass: response at cycle N appears as ins_valid at cycle N+1. Minimum fetch-to-decode latency 2 cycles (req accept N, rsp N+1, ins_valid N+2).
- Redirect at cycle N: imem_req_valid 0 and ins_valid 0 in cycle N+1 until new data; first request at redirect target in cycle N+1.
- Sustained throughput 1 instruction/cycle when memory latency ≤ QDEPTH−1 and ins_ready held high.
- imem_req_addr stable while imem_req_valid && !imem_req_ready, except on redirect.
- rst mid-operation: all state returns to reset values next edge; in-flight responses after reset are treated as protocol errors (memory must also be reset).

## Test plan
- Reset then ins_ready=1, memory latency 1, ready always: requests 0x0,0x4,0x8…; ins_pc 0x0 at cycle 2 after release, then one instruction per cycle with ins = memory contents.
- ins_ready=0 held: exactly 4 requests accepted (outstanding+count=4), imem_req_valid stays 0; raising ins_ready resumes fetch at 0x10.
- Latency 3, three requests outstanding, redirect_pc=0x1002: queue flushes, next 3 responses dropped, first ins_pc = 0x1000 with the word from 0x1000.
- Redirect coinciding with imem_rsp_valid and ins_valid&&ins_ready: response dropped, discard = outstanding−1, no pop effect, count 0 next cycle.
- imem_req_ready toggling 1/0 randomly: imem_req_addr held while stalled; ins sequence contiguous with no duplicates or gaps.
- RESET_PC=32'hFFFF_FFF8: fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in order; ins_pc wraps identically.
